// File: rtl/onehot_capture_if.sv
// Bus bundle between a 2-to-4 decoder source and the one-hot capture stage.
interface onehot_capture_if #(
    parameter int unsigned CW = 8
);
    logic          start;
    logic          clear;
    logic          sample;
    logic          D3;
    logic          D2;
    logic          D1;
    logic          D0;
    logic [1:0]    rd_sel;
    logic          Y1;
    logic          Y0;
    logic          vld;
    logic          err;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [CW-1:0] err_cnt;

    modport master (
        output start, clear, sample, D3, D2, D1, D0, rd_sel,
        input  Y1, Y0, vld, err, busy, cnt, err_cnt
    );

    modport slave (
        input  start, clear, sample, D3, D2, D1, D0, rd_sel,
        output Y1, Y0, vld, err, busy, cnt, err_cnt
    );
endinterface

// File: rtl/onehot_capture.sv
// Captures one-hot decoder lines on a strobe, re-encodes them to a 2-bit index,
// keeps saturating per-line hit counters and flags non-one-hot patterns.
module onehot_capture #(
    parameter int unsigned CW          = 8,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    onehot_capture_if.slave  bus
);
    localparam int unsigned NLINES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    d;
    logic          one_hot;
    logic [1:0]    idx;
    logic          cap_ok;
    logic          cap_bad;
    logic [1:0]    y_q;
    logic          vld_q;
    logic          err_q;
    logic          busy_q;
    logic [CW-1:0] hit_q [NLINES];
    logic [CW-1:0] err_cnt_q;

    assign d = {bus.D3, bus.D2, bus.D1, bus.D0};

    // Encode the line pattern; anything other than a single high line is bad.
    always_comb begin
        one_hot = 1'b0;
        idx     = 2'd0;
        case (d)
            4'b0001: begin one_hot = 1'b1; idx = 2'd0; end
            4'b0010: begin one_hot = 1'b1; idx = 2'd1; end
            4'b0100: begin one_hot = 1'b1; idx = 2'd2; end
            4'b1000: begin one_hot = 1'b1; idx = 2'd3; end
            default: begin one_hot = 1'b0; idx = 2'd0; end
        endcase
    end

    // Next state and capture decode; clear beats start beats sample.
    always_comb begin
        state_next = state;
        cap_ok     = 1'b0;
        cap_bad    = 1'b0;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) state_next = RUN;
                end
                RUN: begin
                    if (bus.sample) begin
                        if (one_hot) begin
                            cap_ok = 1'b1;
                        end else begin
                            cap_bad = 1'b1;
                            if (HALT_ON_ERR) state_next = HALT;
                        end
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture datapath: index, strobe, sticky error and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= 2'd0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < int'(NLINES); i++) hit_q[i] <= '0;
        end else if (bus.clear) begin
            y_q       <= 2'd0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < int'(NLINES); i++) hit_q[i] <= '0;
        end else begin
            vld_q  <= cap_ok;
            busy_q <= (state_next == RUN);
            if (cap_ok) begin
                y_q <= idx;
                if (hit_q[idx] != {CW{1'b1}}) hit_q[idx] <= hit_q[idx] + CW'(1);
            end
            if (cap_bad) begin
                err_q <= 1'b1;
                if (err_cnt_q != {CW{1'b1}}) err_cnt_q <= err_cnt_q + CW'(1);
            end
        end
    end

    assign bus.Y1      = y_q[1];
    assign bus.Y0      = y_q[0];
    assign bus.vld     = vld_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.cnt     = hit_q[bus.rd_sel];
endmodule

// File: tb/tb_onehot_capture.sv
// Bench for onehot_capture: halting CW=8 instance and non-halting CW=4 instance.
module tb_onehot_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int a_vld_cnt = 0;
    int b_vld_cnt = 0;

    logic [1:0] qa [$];
    logic [1:0] qb [$];

    onehot_capture_if #(.CW(8)) ifa ();
    onehot_capture_if #(.CW(4)) ifb ();

    onehot_capture #(.CW(8), .HALT_ON_ERR(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    onehot_capture #(.CW(4), .HALT_ON_ERR(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_cycle(input logic st, input logic cl, input logic sm,
                           input logic [3:0] d, input bit push, input logic [1:0] y);
        ifa.start  = st;
        ifa.clear  = cl;
        ifa.sample = sm;
        {ifa.D3, ifa.D2, ifa.D1, ifa.D0} = d;
        if (push) qa.push_back(y);
        @(negedge clk);
    endtask

    task automatic b_cycle(input logic st, input logic cl, input logic sm,
                           input logic [3:0] d, input bit push, input logic [1:0] y);
        ifb.start  = st;
        ifb.clear  = cl;
        ifb.sample = sm;
        {ifb.D3, ifb.D2, ifb.D1, ifb.D0} = d;
        if (push) qb.push_back(y);
        @(negedge clk);
    endtask

    task automatic a_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        ifa.rd_sel = sel;
        #1;
        check(tag, 32'(ifa.cnt), exp);
    endtask

    task automatic b_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        ifb.rd_sel = sel;
        #1;
        check(tag, 32'(ifb.cnt), exp);
    endtask

    // Scoreboard for instance A: every vld pulse must match a queued index.
    always @(negedge clk) begin
        if (!rst && ifa.vld) begin
            a_vld_cnt++;
            if (qa.size() == 0) check("a_vld_unexpected", 32'(1), 32'(0));
            else                check("a_y", 32'({ifa.Y1, ifa.Y0}), 32'(qa.pop_front()));
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (!rst && ifb.vld) begin
            b_vld_cnt++;
            if (qb.size() == 0) check("b_vld_unexpected", 32'(1), 32'(0));
            else                check("b_y", 32'({ifb.Y1, ifb.Y0}), 32'(qb.pop_front()));
        end
    end

    initial begin
        ifa.start = 0; ifa.clear = 0; ifa.sample = 0; ifa.rd_sel = 0;
        {ifa.D3, ifa.D2, ifa.D1, ifa.D0} = 4'b0000;
        ifb.start = 0; ifb.clear = 0; ifb.sample = 0; ifb.rd_sel = 0;
        {ifb.D3, ifb.D2, ifb.D1, ifb.D0} = 4'b0000;

        // Asynchronous reset values
        #1 rst = 1'b1;
        #2;
        check("rst_y",       32'({ifa.Y1, ifa.Y0}), 32'(0));
        check("rst_vld",     32'(ifa.vld), 32'(0));
        check("rst_err",     32'(ifa.err), 32'(0));
        check("rst_busy",    32'(ifa.busy), 32'(0));
        check("rst_cnt",     32'(ifa.cnt), 32'(0));
        check("rst_err_cnt", 32'(ifa.err_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // A: start, then one capture per line back-to-back
        a_cycle(1, 0, 0, 4'b0000, 0, 0);
        check("a_busy_run", 32'(ifa.busy), 32'(1));
        a_cycle(0, 0, 1, 4'b0001, 1, 2'd0);
        check("a_vld_p0", 32'(ifa.vld), 32'(1));
        a_cycle(0, 0, 1, 4'b0010, 1, 2'd1);
        check("a_vld_p1", 32'(ifa.vld), 32'(1));
        a_cycle(0, 0, 1, 4'b0100, 1, 2'd2);
        a_cycle(1, 0, 1, 4'b1000, 1, 2'd3);
        a_cycle(0, 0, 0, 4'b0000, 0, 0);
        check("a_vld_idle", 32'(ifa.vld), 32'(0));
        check("a_y_hold", 32'({ifa.Y1, ifa.Y0}), 32'(3));
        check("a_err0", 32'(ifa.err), 32'(0));
        for (int i = 0; i < 4; i++) a_cnt($sformatf("a_hit%0d", i), 2'(i), 32'(1));

        // A: multi-hot pattern halts
        a_cycle(0, 0, 1, 4'b0110, 0, 0);
        check("a_err_set", 32'(ifa.err), 32'(1));
        check("a_err_cnt1", 32'(ifa.err_cnt), 32'(1));
        check("a_vld_bad", 32'(ifa.vld), 32'(0));
        check("a_busy_halt", 32'(ifa.busy), 32'(0));
        check("a_y_bad_hold", 32'({ifa.Y1, ifa.Y0}), 32'(3));
        a_cycle(1, 0, 1, 4'b0001, 0, 0);
        a_cycle(0, 0, 0, 4'b0000, 0, 0);
        check("a_halt_err_cnt", 32'(ifa.err_cnt), 32'(1));
        check("a_halt_busy", 32'(ifa.busy), 32'(0));
        a_cnt("a_halt_hit0", 2'd0, 32'(1));

        // A: clear exits HALT and zeroes everything
        a_cycle(0, 1, 0, 4'b0000, 0, 0);
        check("a_clr_err", 32'(ifa.err), 32'(0));
        check("a_clr_err_cnt", 32'(ifa.err_cnt), 32'(0));
        check("a_clr_y", 32'({ifa.Y1, ifa.Y0}), 32'(0));
        a_cnt("a_clr_hit3", 2'd3, 32'(0));

        // A: clear with a simultaneous sample after three hits
        a_cycle(1, 0, 0, 4'b0000, 0, 0);
        a_cycle(0, 0, 1, 4'b0001, 1, 2'd0);
        a_cycle(0, 0, 1, 4'b0010, 1, 2'd1);
        a_cycle(0, 0, 1, 4'b0001, 1, 2'd0);
        a_cnt("a_pre_clr_hit0", 2'd0, 32'(2));
        a_cycle(0, 1, 1, 4'b0100, 0, 0);
        check("a_clrs_vld", 32'(ifa.vld), 32'(0));
        check("a_clrs_busy", 32'(ifa.busy), 32'(0));
        for (int i = 0; i < 4; i++) a_cnt($sformatf("a_clrs_hit%0d", i), 2'(i), 32'(0));
        a_cycle(0, 0, 1, 4'b0001, 0, 0);
        check("a_idle_vld", 32'(ifa.vld), 32'(0));
        a_cnt("a_idle_hit0", 2'd0, 32'(0));

        // B: non-halting error, then capture continues
        b_cycle(1, 0, 0, 4'b0000, 0, 0);
        b_cycle(0, 0, 1, 4'b0000, 0, 0);
        check("b_err", 32'(ifb.err), 32'(1));
        check("b_err_cnt", 32'(ifb.err_cnt), 32'(1));
        check("b_vld_bad", 32'(ifb.vld), 32'(0));
        check("b_busy", 32'(ifb.busy), 32'(1));
        b_cycle(0, 0, 1, 4'b0100, 1, 2'd2);
        check("b_y2", 32'({ifb.Y1, ifb.Y0}), 32'(2));
        b_cnt("b_hit2", 2'd2, 32'(1));

        // B: CW=4 saturation after 17 captures
        for (int i = 0; i < 17; i++) b_cycle(0, 0, 1, 4'b1000, 1, 2'd3);
        b_cycle(0, 0, 0, 4'b0000, 0, 0);
        b_cnt("b_hit3_sat", 2'd3, 32'(15));
        check("b_vld_pulses", 32'(b_vld_cnt), 32'(18));
        check("b_err_cnt_hold", 32'(ifb.err_cnt), 32'(1));

        // A: asynchronous reset mid-RUN with live counters
        a_cycle(1, 0, 0, 4'b0000, 0, 0);
        a_cycle(0, 0, 1, 4'b1000, 1, 2'd3);
        a_cycle(0, 0, 1, 4'b0100, 1, 2'd2);
        a_cycle(0, 0, 1, 4'b0011, 0, 0);
        check("a_err_pre_rst", 32'(ifa.err), 32'(1));
        ifa.rd_sel = 2'd3;
        #2 rst = 1'b1;
        #1;
        check("arst_y",       32'({ifa.Y1, ifa.Y0}), 32'(0));
        check("arst_vld",     32'(ifa.vld), 32'(0));
        check("arst_err",     32'(ifa.err), 32'(0));
        check("arst_busy",    32'(ifa.busy), 32'(0));
        check("arst_cnt3",    32'(ifa.cnt), 32'(0));
        check("arst_err_cnt", 32'(ifa.err_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        a_cycle(0, 0, 0, 4'b0000, 0, 0);

        check("a_vld_pulses", 32'(a_vld_cnt), 32'(9));
        check("a_queue_empty", 32'(qa.size()), 32'(0));
        check("b_queue_empty", 32'(qb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
